// File: rtl/siso.sv
// Serial-in serial-out shift register: a fixed DEPTH-clock bit delay line.
// q comes straight off the last stage flop, so nothing from d reaches it combinationally.
module siso #(
    parameter int   DEPTH     = 4,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    // stage[0] is the input end; each stage takes its neighbour's old value.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stage_q <= {DEPTH{RESET_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: tb/tb_siso.sv
// Self-checking bench for siso: directed table, hand sequences and a random soak,
// run on three parameterisations against a reset-aware history reference.
module tb_siso;

    logic clock;
    logic reset;
    logic d;
    logic q4, q1, q16;

    siso #(.DEPTH(4),  .RESET_VAL(1'b0)) u_d4  (.clock(clock), .reset(reset), .d(d), .q(q4));
    siso #(.DEPTH(1),  .RESET_VAL(1'b1)) u_d1  (.clock(clock), .reset(reset), .d(d), .q(q1));
    siso #(.DEPTH(16), .RESET_VAL(1'b0)) u_d16 (.clock(clock), .reset(reset), .d(d), .q(q16));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // History of what was presented on every edge so far.
    logic hr[$];
    logic hd[$];

    typedef struct {
        logic r;
        logic d;
        logic e;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // q after the latest edge is the d from D edges back, unless any of the last D edges was a reset.
    function automatic logic ref_q(input int D, input logic rv);
        int n = hr.size() - 1;
        for (int k = 0; k < D; k++) begin
            if (n - k < 0) return rv;
            if (!hr[n-k]) return rv;
        end
        return hd[n-D+1];
    endfunction

    task automatic step(input logic r, input logic dv);
        @(negedge clock);
        reset = r;
        d     = dv;
        @(posedge clock);
        #1;
        hr.push_back(r);
        hd.push_back(dv);
        chk("model_d4",  q4,  ref_q(4, 1'b0));
        chk("model_d1",  q1,  ref_q(1, 1'b1));
        chk("model_d16", q16, ref_q(16, 1'b0));
    endtask

    function automatic void add(input logic r, input logic dv, input logic e);
        vec_t v;
        v.r = r; v.d = dv; v.e = e;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0] pat;
        int         cnt;
        bit         seen;
        reset = 1'b0;
        d     = 1'b0;

        // reset hold with d toggling
        add(0, 1, 0); add(0, 0, 0); add(0, 1, 0);
        // latency: single 1 after release
        add(1, 1, 0); add(1, 0, 0); add(1, 0, 0); add(1, 0, 1); add(1, 0, 0);
        // pattern 8'b1011_0010 LSB first, then flush zeros
        pat = 8'b1011_0010;
        for (int i = 0; i < 12; i++) begin
            logic bi, ei;
            bi = (i < 8) ? pat[i] : 1'b0;
            ei = (i >= 3 && i - 3 < 8) ? pat[i-3] : 1'b0;
            add(1, bi, ei);
        end
        // mid-stream reset flushes four in-flight ones
        add(1, 1, 0); add(1, 1, 0); add(1, 1, 0); add(1, 1, 1);
        add(0, 1, 0);
        add(1, 0, 0); add(1, 0, 0); add(1, 0, 0); add(1, 0, 0); add(1, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].d);
            chk($sformatf("vec%0d_d4", i), q4, vecs[i].e);
        end

        // DEPTH=1 resets to 1 and then follows d one clock late
        step(0, 0);
        chk("d1_reset", q1, 1'b1);
        step(1, 0);
        chk("d1_follow0", q1, 1'b0);
        step(1, 1);
        chk("d1_follow1", q1, 1'b1);

        // DEPTH=16: count edges until a lone 1 emerges
        step(0, 0);
        step(1, 1);
        cnt  = 1;
        seen = (q16 === 1'b1);
        while (!seen && cnt < 40) begin
            step(1, 0);
            cnt++;
            seen = (q16 === 1'b1);
        end
        tests++;
        if (!seen || cnt != 16) begin
            fails++;
            $display("FAIL d16_delay: got %0d edges (seen=%0b) expected 16", cnt, seen);
        end
        step(1, 0);
        chk("d16_single", q16, 1'b0);

        // random soak with sporadic reset pulses
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 24) != 0), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
